// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO with a registered read port and full/empty
// flags. The name is kept for drop-in compatibility; there is no clock-domain
// crossing. Pointers carry one extra wrap bit so that full and empty can be
// told apart when the storage indices are equal.
module async_fifo #(
   parameter int FIFO_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [FIFO_WIDTH-1:0] din,
   input  logic                  rd_en,
   output logic [FIFO_WIDTH-1:0] dout,
   output logic                  empty,
   output logic                  full
);

   typedef logic [ADDR_WIDTH:0]   ptr_t;
   typedef logic [FIFO_WIDTH-1:0] word_t;

   localparam ptr_t PTR_ONE = ptr_t'(1);

   ptr_t  wr_ptr_q, wr_ptr_d;
   ptr_t  rd_ptr_q, rd_ptr_d;
   word_t dout_q, dout_d;
   word_t mem_q [FIFO_DEPTH];

   logic wr_accept;
   logic rd_accept;

   // Flags derive only from the registered pointers.
   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
              (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
   end

   // Accept decisions and next-state values for pointers and read data.
   always_comb begin
      // NOTE: every output of this block is assigned a default first so no
      // path leaves a value unassigned, which would infer a latch.
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      dout_d    = dout_q;
      rd_accept = rd_en && !empty;
      // When full, a simultaneous read frees the slot this write lands in.
      wr_accept = wr_en && (!full || rd_accept);
      if (rd_accept) begin
         dout_d   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
   end

   // Pointer and read-data registers, cleared by the asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         dout_q   <= dout_d;
      end
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      // NOTE: the array is deliberately not reset; the pointers alone define
      // which entries are valid, and leaving it reset-free lets it map to RAM.
      if (wr_accept) begin
         mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= din;
      end
   end

   assign dout = dout_q;

endmodule

// File: tb/tb_async_fifo.sv
// Directed self-checking bench for async_fifo: reset, fill/drain past the
// limits, pointer wrap, simultaneous access and asynchronous reset mid-stream.
`timescale 1ns/1ps
module tb_async_fifo;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [7:0] din;
   logic       rd_en;
   logic [7:0] dout;
   logic       empty;
   logic       full;

   int total = 0;
   int bad   = 0;

   async_fifo #(
      .FIFO_WIDTH(8),
      .FIFO_DEPTH(16),
      .ADDR_WIDTH(4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .wr_en (wr_en),
      .din   (din),
      .rd_en (rd_en),
      .dout  (dout),
      .empty (empty),
      .full  (full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one rising edge and settle 1 ns past it before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      wr_en = 1'b1; rd_en = 1'b0; din = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] d);
      wr_en = 1'b0; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check(tag, dout, d);
   endtask

   initial begin
      wr_en = 1'b0; rd_en = 1'b0; din = '0;

      // Reset held for three cycles.
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_dout", dout, 0);
      rst = 1'b0;
      tick();
      check("post_rst_empty", empty, 1);
      check("post_rst_full", full, 0);
      check("post_rst_dout", dout, 0);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("underflow_dout", dout, 0);
      check("underflow_empty", empty, 1);

      // Fill past capacity: 0..15 then two extra 15s that must be dropped.
      for (int i = 0; i < 18; i++) begin
         wr_en = 1'b1;
         din   = (i < 16) ? 8'(i) : 8'd15;
         tick();
         check("fill_empty", empty, 0);
         check("fill_full", full, (i >= 15) ? 1 : 0);
      end
      wr_en = 1'b0;

      // Drain past empty: 0..15, then dout holds 15.
      for (int i = 0; i < 18; i++) begin
         rd_en = 1'b1;
         tick();
         check("drain_dout", dout, (i < 16) ? i : 15);
         check("drain_full", full, 0);
         check("drain_empty", empty, (i >= 15) ? 1 : 0);
      end
      rd_en = 1'b0;

      // Wrap: three rounds of 10 in / 10 out, pointers cross the boundary.
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 10; k++) begin
            push(8'(8'h40 + 16 * r + k));
            check("wrap_full", full, 0);
         end
         for (int k = 0; k < 10; k++) pop_expect("wrap_dout", 8'(8'h40 + 16 * r + k));
         check("wrap_empty", empty, 1);
      end

      // Simultaneous read/write at 8 entries for 20 cycles.
      for (int k = 0; k < 8; k++) push(8'(8'h80 + k));
      for (int k = 0; k < 20; k++) begin
         wr_en = 1'b1; rd_en = 1'b1; din = 8'(8'h88 + k);
         tick();
         check("sim8_dout", dout, 8'h80 + k);
         check("sim8_empty", empty, 0);
         check("sim8_full", full, 0);
      end
      wr_en = 1'b0; rd_en = 1'b0;
      for (int k = 0; k < 8; k++) pop_expect("sim8_tail", 8'(8'h94 + k));
      check("sim8_done_empty", empty, 1);

      // Simultaneous read/write while full.
      for (int k = 0; k < 16; k++) push(8'(8'hC0 + k));
      check("full_before", full, 1);
      wr_en = 1'b1; rd_en = 1'b1; din = 8'hEE;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      check("full_rw_dout", dout, 8'hC0);
      check("full_rw_full", full, 1);
      for (int k = 1; k < 16; k++) pop_expect("full_rw_drain", 8'(8'hC0 + k));
      pop_expect("full_rw_last", 8'hEE);
      check("full_rw_empty", empty, 1);

      // Asynchronous reset between edges at 5 entries.
      for (int k = 0; k < 6; k++) push(8'(8'h10 + k));
      pop_expect("pre_arst_dout", 8'h10);
      #3 rst = 1'b1;
      #1;
      check("arst_empty", empty, 1);
      check("arst_full", full, 0);
      check("arst_dout", dout, 0);
      #1 rst = 1'b0;
      push(8'h5A);
      check("after_arst_empty", empty, 0);
      pop_expect("after_arst_dout", 8'h5A);
      check("after_arst_drained", empty, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/async_fifo.md
Name: async_fifo

Overview:
- Single-clock, synchronous-read FIFO buffer with a write port (wr_en/din), a read port (rd_en/dout), and full/empty status flags.
- Sits between a producer and a consumer in the same clock domain.
- Keeps the async_fifo interface name for drop-in compatibility; there is no clock-domain crossing.

Parameters:
- FIFO_WIDTH, 8, data word width in bits.
- FIFO_DEPTH, 16, number of storage entries; must be a power of two.
- ADDR_WIDTH, 4, log2(FIFO_DEPTH); storage address width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request.
- din  input  FIFO_WIDTH  write data.
- rd_en  input  1  read request.
- dout  output  FIFO_WIDTH  registered read data.
- empty  output  1  high when the FIFO holds 0 entries.
- full  output  1  high when the FIFO holds FIFO_DEPTH entries.

Behaviour:
- Reset is asynchronous and active-high. rst=1 immediately clears:
  - wr_ptr=0, rd_ptr=0, dout=0
  - empty=1, full=0
- Storage array contents are not reset.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide.
  - The low ADDR_WIDTH bits index storage; the MSB is a wrap flag.
  - Both pointers increment modulo 2^(ADDR_WIDTH+1).
- Flags are combinational from the registered pointers, so they are valid the cycle after the pointer update:
  - empty = (wr_ptr == rd_ptr)
  - full = (MSBs differ) and (low ADDR_WIDTH bits equal)
- Write:
  - Accepted at the clk edge when wr_en=1 and full=0.
  - mem[wr_ptr low bits] <= din; wr_ptr increments.
  - A write while full is silently dropped: no pointer change, no data corruption.
- Read:
  - Accepted at the clk edge when rd_en=1 and empty=0.
  - dout <= mem[rd_ptr low bits]; rd_ptr increments.
  - Latency is 1 cycle: data appears on dout after the accepting edge.
  - A read while empty is ignored; dout holds its previous value.
- Simultaneous wr_en=1 and rd_en=1:
  - Not full and not empty: both proceed; occupancy unchanged; flags unchanged.
  - Full: the read proceeds and the write is also accepted (uses the slot being freed); FIFO stays full.
  - Empty: only the write proceeds; dout unchanged; empty deasserts next cycle. There is no first-word fall-through.
- Wrap-around: after FIFO_DEPTH writes and reads, pointers wrap seamlessly; data order is preserved (strict FIFO).
- dout holds its value when no read is accepted.
- Reset mid-operation discards all contents; the FIFO is empty the instant rst asserts.
- No overflow or underflow error outputs; dropped operations are silent.

Test Plan:
- Reset: hold rst=1 for 3 cycles, then release -> empty=1, full=0, dout=0; a read with rd_en=1 leaves dout=0 and empty=1.
- Fill past capacity: wr_en=1 for 18 cycles with din=0..15, then 15, 15 ->
  - empty drops after the first write;
  - full asserts after the 16th write;
  - the last two writes are dropped.
- Drain: wr_en=0, rd_en=1 for 18 cycles ->
  - dout = 0,1,...,15 on consecutive cycles, each one cycle after the accepting edge;
  - full drops after the first read; empty asserts after the 16th read;
  - the final two reads leave dout=15.
- Wrap: 3 rounds of writing 10 words, then reading 10 words (pointers cross the 16 boundary) -> data returned in order; empty=1 after each round; full never asserts.
- Simultaneous access:
  - At 8 entries, wr_en=rd_en=1 for 20 cycles -> occupancy stays 8; output sequence is continuous.
  - When full, both asserted -> full stays 1 and the written word is read out later in order.
- Async reset mid-stream: assert rst between clock edges at 5 entries -> empty=1, full=0, dout=0 immediately; the next write/read returns the new data only.
